// File: rtl/lzc_pipe_norm.sv
// Pipelined leading/trailing zero counter with normaliser.
// Each accepted beat counts zeros from the MSB (mode 0) or LSB (mode 1) and
// returns the operand shifted so its first set bit lands on the MSB or LSB.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync valid clear)
//   in_valid_i / in_ready_o / in_data_i / in_mode_i / in_tag_i : input stream
//   out_valid_o / out_ready_i / cnt_o / norm_o / empty_o / tag_o : result stream
// Latency is exactly STAGES cycles; up to STAGES beats buffer under stall.
module lzc_pipe_norm #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic                 in_mode_i,
  input  logic [TAG_WIDTH-1:0] in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0]     norm_o,
  output logic                 empty_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  // Payload per stage: {cnt, norm, empty, tag}
  localparam int unsigned PAY_W = CNT_WIDTH + WIDTH + 1 + TAG_WIDTH;

  logic [CNT_WIDTH-1:0] lz_c;
  logic [CNT_WIDTH-1:0] tz_c;
  logic [CNT_WIDTH-1:0] cnt_c;
  logic [WIDTH-1:0]     norm_c;
  logic                 empty_c;

  logic [STAGES-1:0]    vld_q;
  logic [STAGES-1:0]    vld_d;
  logic [STAGES-1:0]    ld_c;
  logic [STAGES-1:0]    rdy_c;
  logic [STAGES-1:0]    src_vld_c;
  logic [PAY_W-1:0]     pay_q     [STAGES];
  logic [PAY_W-1:0]     src_pay_c [STAGES];

  // Zero counts: the last hit in each scan direction is the first set bit.
  always_comb begin
    lz_c = CNT_WIDTH'(WIDTH);
    tz_c = CNT_WIDTH'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_data_i[i]) lz_c = CNT_WIDTH'(WIDTH - 1 - i);
    end
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_data_i[i]) tz_c = CNT_WIDTH'(i);
    end
  end

  // A shift by WIDTH on the empty operand already yields zero.
  assign cnt_c   = in_mode_i ? tz_c : lz_c;
  assign empty_c = ~|in_data_i;
  assign norm_c  = in_mode_i ? (in_data_i >> cnt_c) : (in_data_i << cnt_c);

  // Stage k is ready when it, or any stage after it, has a free slot, or the
  // sink takes the output. Computed per stage to avoid a self-referencing chain.
  always_comb begin
    logic all_full;
    rdy_c = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      all_full = 1'b1;
      for (int j = k; j < int'(STAGES); j++) begin
        all_full = all_full & vld_q[j];
      end
      rdy_c[k] = ~all_full | out_ready_i;
    end
  end

  assign in_ready_o = rdy_c[0];

  // Sources for each stage and next-state valid bits / load enables.
  always_comb begin
    src_vld_c    = '0;
    src_vld_c[0] = in_valid_i;
    src_pay_c[0] = {cnt_c, norm_c, empty_c, in_tag_i};
    for (int k = 1; k < int'(STAGES); k++) begin
      src_vld_c[k] = vld_q[k-1];
      src_pay_c[k] = pay_q[k-1];
    end
    vld_d = vld_q;
    ld_c  = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (flush_i)       vld_d[k] = 1'b0;
      else if (rdy_c[k]) vld_d[k] = src_vld_c[k];
      ld_c[k] = rdy_c[k] & src_vld_c[k] & ~flush_i;
    end
  end

  // Stage registers; data only moves with a valid beat so stalled outputs hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) pay_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (ld_c[k]) pay_q[k] <= src_pay_c[k];
      end
    end
  end

  assign out_valid_o                      = vld_q[STAGES-1];
  assign {cnt_o, norm_o, empty_o, tag_o}  = pay_q[STAGES-1];

endmodule

// File: doc/lzc_pipe_norm.md
Name: lzc_pipe_norm

Overview:
- Pipelined, parametrised zero counter with normaliser.
- Per transaction it counts leading zeros (from the MSB) or trailing zeros (from the LSB) of a WIDTH-bit operand, selected at run time by a mode bit.
- It also returns the operand shifted so that the first set bit is at the MSB (leading mode) or at the LSB (trailing mode).
- Sits in FP-normalisation and priority-select datapaths behind a valid/ready stream, carrying a sideband tag.

Parameters:
- WIDTH, 32, operand width; legal range 2..256.
- STAGES, 2, register stages from input to output; exact latency in cycles; legal range 1..4.
- TAG_WIDTH, 4, width of the sideband tag passed through unchanged; legal range ≥1.
- CNT_WIDTH, $clog2(WIDTH+1), count width; must hold the value WIDTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous pipeline clear.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- in_data_i  in  WIDTH  operand.
- in_mode_i  in  1  0 = leading-zero count, 1 = trailing-zero count.
- in_tag_i  in  TAG_WIDTH  sideband tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- cnt_o  out  CNT_WIDTH  zero count.
- norm_o  out  WIDTH  normalised operand.
- empty_o  out  1  operand was all zeros.
- tag_o  out  TAG_WIDTH  tag of this result.

Behaviour:
- Handshake:
  - A beat is accepted on a cycle with in_valid_i & in_ready_o.
  - A beat is delivered on a cycle with out_valid_o & out_ready_i.
- Output registers:
  - STAGES pipeline registers, each holding its own valid bit; the last stage drives the outputs directly from flops.
  - Stage k ready = !valid_k | ready_(k+1), where ready after the last stage = out_ready_i. in_ready_o = ready of stage 1.
  - The combinational ready path is permitted.
  - Full throughput: one beat per cycle while out_ready_i=1.
- Latency: a beat accepted in cycle t appears with out_valid_o=1 in cycle t+STAGES when no stall occurs.
- Stalls:
  - While out_valid_o=1 and out_ready_i=0, every output holds stable.
  - Up to STAGES beats buffer inside the block; no beat is dropped or duplicated; order is preserved.
- Arithmetic, leading mode (in_mode_i=0):
  - cnt = number of consecutive 0 bits from bit WIDTH-1 downward.
  - norm = in_data << cnt, with zero fill.
- Arithmetic, trailing mode (in_mode_i=1):
  - cnt = number of consecutive 0 bits from bit 0 upward.
  - norm = in_data >> cnt, with zero fill.
- Empty operand (in_data_i=0): cnt_o=WIDTH, norm_o=0, empty_o=1, in either mode. Otherwise empty_o=0 and cnt_o is in 0..WIDTH-1.
- Internal partitioning: the split of count tree and shifter across stages is an implementation choice. Outputs must be bit-identical to the definition above for every STAGES value.
- Mode and tag are captured with the data and travel with it. A mode change between consecutive beats needs no bubble.
- flush_i:
  - Clears all stage valid bits at the next edge; data registers keep their contents.
  - A beat presented in the same cycle as flush_i=1 is discarded.
  - in_ready_o is unaffected.
  - flush_i and rst_i together behave as reset.
- Reset, on the next edge with rst_i=1:
  - All valid bits go to 0, so out_valid_o=0.
  - cnt_o, norm_o, empty_o and tag_o go to 0.
  - in_ready_o is 1 from the first cycle after reset, since all stages are empty.
  - Reset mid-stream discards all in-flight beats.
- X/Z on in_data_i need not be defined; no X may propagate into the valid bits.

Test Plan:
- WIDTH=8, STAGES=2: in_data=0001_0110, mode=0, tag=3, out_ready=1 → two cycles later out_valid=1, cnt=3, norm=1011_0000, empty=0, tag=3.
- Same operand with mode=1 → cnt=1, norm=0000_1011, empty=0.
- in_data=0000_0000, mode 0 and then mode 1 → cnt=8, norm=0, empty=1 for both beats.
- Boundaries:
  - 1000_0000 mode=0 → cnt=0, norm=1000_0000.
  - 1000_0000 mode=1 → cnt=7, norm=0000_0001.
  - 0000_0001 mode=0 → cnt=7, norm=1000_0000.
- Backpressure: stream tags 0..5 back-to-back while out_ready=0 for 6 cycles, then 1.
  - Required: exactly 2 beats accepted; in_ready low from that point; outputs stable while stalled.
  - Tags 0..5 emerge in order with correct counts; sustained 1 beat/cycle once released.
- Flush and reset:
  - Pulse flush_i with 2 beats in flight → no out_valid for them; the next accepted beat arrives after 2 cycles.
  - Assert rst_i mid-stream → out_valid=0, cnt_o=norm_o=tag_o=0 the cycle after; in_ready=1.
